// File: rtl/matmul_engine.sv
// Sequential matrix multiplier C = A x B using one multiply-accumulate lane.
// Ports: start/abort/config in; A/B read ports; C write port; busy/done/err/ovf.
module matmul_engine #(
  parameter int M      = 4,
  parameter int N      = 4,
  parameter int K      = 32,
  parameter int DATA_W = 8,
  parameter int OUT_W  = 16,
  parameter int ACC_W  = 2*DATA_W+$clog2(K)+1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    abort,
  input  logic [$clog2(K+1)-1:0]  k_len,
  input  logic                    signed_en,
  input  logic                    sat_en,
  output logic [$clog2(M*K)-1:0]  a_addr,
  input  logic [DATA_W-1:0]       a_data,
  output logic [$clog2(K*N)-1:0]  b_addr,
  input  logic [DATA_W-1:0]       b_data,
  output logic                    c_we,
  output logic [$clog2(M*N)-1:0]  c_addr,
  output logic [OUT_W-1:0]        c_data,
  output logic                    busy,
  output logic                    done,
  output logic                    err,
  output logic                    ovf
);

  localparam int KL_W = $clog2(K+1);
  localparam int AA_W = $clog2(M*K);
  localparam int BA_W = $clog2(K*N);
  localparam int CA_W = $clog2(M*N);
  localparam int I_W  = (M > 1) ? $clog2(M) : 1;
  localparam int J_W  = (N > 1) ? $clog2(N) : 1;
  localparam int P_W  = 2*DATA_W;

  localparam logic signed [ACC_W-1:0] S_MAX = ACC_W'((2**(OUT_W-1))-1);
  localparam logic signed [ACC_W-1:0] S_MIN = ACC_W'(-(2**(OUT_W-1)));
  localparam logic signed [ACC_W-1:0] U_MAX = ACC_W'((2**OUT_W)-1);

  typedef enum logic [2:0] {IDLE, ISSUE, DRAIN, WRITE, FIN} state_t;

  state_t state_q, state_d;
  logic [I_W-1:0]  i_q, i_d;
  logic [J_W-1:0]  j_q, j_d;
  logic [KL_W-1:0] k_q, k_d;
  logic [KL_W-1:0] kl_q, kl_d;
  logic sgn_q, sgn_d;
  logic sat_q, sat_d;
  logic ovf_q, ovf_d;
  logic err_q, err_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;

  logic signed [P_W-1:0]   prod_s;
  logic [P_W-1:0]          prod_u;
  logic signed [ACC_W-1:0] prod_x;
  logic signed [ACC_W-1:0] conv_x;
  logic [OUT_W-1:0]        conv;
  logic legal, last_k, last_el, ovf_hit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      i_q     <= '0;
      j_q     <= '0;
      k_q     <= '0;
      kl_q    <= '0;
      sgn_q   <= 1'b0;
      sat_q   <= 1'b0;
      ovf_q   <= 1'b0;
      err_q   <= 1'b0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      k_q     <= k_d;
      kl_q    <= kl_d;
      sgn_q   <= sgn_d;
      sat_q   <= sat_d;
      ovf_q   <= ovf_d;
      err_q   <= err_d;
      acc_q   <= acc_d;
    end
  end

  assign legal   = (k_len != '0) && (k_len <= KL_W'(K));
  assign last_k  = (k_q == kl_q - KL_W'(1));
  assign last_el = (i_q == I_W'(M-1)) && (j_q == J_W'(N-1));

  // Operands are widened per the latched mode so the sum never wraps.
  always_comb begin
    prod_s = $signed(a_data) * $signed(b_data);
    prod_u = a_data * b_data;
    if (sgn_q)
      prod_x = {{(ACC_W-P_W){prod_s[P_W-1]}}, prod_s};
    else
      prod_x = {{(ACC_W-P_W){1'b0}}, prod_u};
  end

  // Result conversion; ovf_hit flags any value change.
  always_comb begin
    conv = acc_q[OUT_W-1:0];
    if (sat_q) begin
      if (sgn_q) begin
        if (acc_q > S_MAX)      conv = S_MAX[OUT_W-1:0];
        else if (acc_q < S_MIN) conv = S_MIN[OUT_W-1:0];
      end else if (acc_q > U_MAX) begin
        conv = U_MAX[OUT_W-1:0];
      end
    end
    if (sgn_q)
      conv_x = {{(ACC_W-OUT_W){conv[OUT_W-1]}}, conv};
    else
      conv_x = {{(ACC_W-OUT_W){1'b0}}, conv};
    ovf_hit = (conv_x != acc_q);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (start) state_d = legal ? ISSUE : DRAIN;
      ISSUE: if (last_k) state_d = DRAIN;
      // An illegal length spends its single busy cycle here.
      DRAIN: state_d = err_q ? FIN : WRITE;
      WRITE: state_d = last_el ? FIN : ISSUE;
      FIN:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort && state_q != IDLE) state_d = IDLE;
  end

  always_comb begin
    i_d   = i_q;
    j_d   = j_q;
    k_d   = k_q;
    kl_d  = kl_q;
    sgn_d = sgn_q;
    sat_d = sat_q;
    ovf_d = ovf_q;
    err_d = err_q;
    acc_d = acc_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          kl_d  = k_len;
          sgn_d = signed_en;
          sat_d = sat_en;
          ovf_d = 1'b0;
          err_d = ~legal;
          acc_d = '0;
          i_d   = '0;
          j_d   = '0;
          k_d   = '0;
        end
      end
      ISSUE: begin
        if (k_q != '0) acc_d = acc_q + prod_x;
        k_d = k_q + KL_W'(1);
      end
      DRAIN: begin
        if (!err_q) acc_d = acc_q + prod_x;
      end
      WRITE: begin
        if (!abort) begin
          acc_d = '0;
          k_d   = '0;
          ovf_d = ovf_q | ovf_hit;
          if (j_q == J_W'(N-1)) begin
            j_d = '0;
            i_d = last_el ? '0 : i_q + I_W'(1);
          end else begin
            j_d = j_q + J_W'(1);
          end
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    a_addr = AA_W'(int'(i_q) * K + int'(k_q));
    b_addr = BA_W'(int'(k_q) * N + int'(j_q));
    c_addr = CA_W'(int'(i_q) * N + int'(j_q));
    c_data = conv;
    c_we   = (state_q == WRITE) && !abort;
    done   = (state_q == FIN) && !abort;
    err    = (state_q == FIN) && !abort && err_q;
    busy   = (state_q == ISSUE) || (state_q == DRAIN) ||
             (state_q == WRITE);
    ovf    = ovf_q;
  end

endmodule

// File: tb/tb_matmul_engine.sv
// Randomised bench for matmul_engine with a plain-arithmetic reference model.
// Default parameters: M=N=4, K=32, 8-bit operands, 16-bit results.
module tb_matmul_engine;

  localparam int M = 4;
  localparam int N = 4;
  localparam int K = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic signed_en = 1'b0;
  logic sat_en = 1'b0;
  logic [5:0] k_len = '0;
  logic [6:0] a_addr, b_addr;
  logic [7:0] a_data, b_data;
  logic c_we;
  logic [3:0] c_addr;
  logic [15:0] c_data;
  logic busy, done, err, ovf;

  logic [7:0]  a_mem [M*K];
  logic [7:0]  b_mem [K*N];
  logic [15:0] exp_c [M*N];
  bit          exp_v [M*N];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int st_cyc = 0;
  int run_lim = 0;
  int m_kl = 0;
  bit run_act = 0;
  bit m_legal = 0;
  bit exp_ovf = 0;
  bit mon_en = 0;
  int wr_cnt = 0;
  int done_cnt = 0;

  matmul_engine dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .k_len(k_len), .signed_en(signed_en), .sat_en(sat_en),
    .a_addr(a_addr), .a_data(a_data),
    .b_addr(b_addr), .b_data(b_data),
    .c_we(c_we), .c_addr(c_addr), .c_data(c_data),
    .busy(busy), .done(done), .err(err), .ovf(ovf)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Operand buffers with one cycle read latency.
  always @(posedge clk) begin
    a_data <= a_mem[a_addr];
    b_data <= b_mem[b_addr];
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", nm, cyc, act, exp);
    end
  endtask

  function automatic void model(input int kl, input bit sg, input bit sat);
    longint acc, x, y, cv, lo, hi;
    for (int i = 0; i < M; i++) begin
      for (int j = 0; j < N; j++) begin
        acc = 0;
        for (int k = 0; k < kl; k++) begin
          x = longint'(a_mem[i*K+k]);
          y = longint'(b_mem[k*N+j]);
          if (sg && x >= 128) x -= 256;
          if (sg && y >= 128) y -= 256;
          acc += x * y;
        end
        if (sat) begin
          lo = sg ? -32768 : 0;
          hi = sg ? 32767 : 65535;
          cv = (acc > hi) ? hi : (acc < lo) ? lo : acc;
        end else begin
          cv = acc & 64'hFFFF;
          if (sg && cv >= 32768) cv -= 65536;
        end
        exp_c[i*N+j] = cv[15:0];
        exp_v[i*N+j] = (cv != acc);
      end
    end
  endfunction

  // Expected outputs follow from the cycle offset since the start cycle.
  always @(negedge clk) begin
    int rel, per, tot, idx;
    bit e_we, e_busy, e_done, e_err;
    if (mon_en) begin
      rel = cyc - st_cyc;
      e_we = 0; e_busy = 0; e_done = 0; e_err = 0; idx = 0;
      if (rst) begin
        exp_ovf = 0;
      end else if (run_act && rel >= 1 && rel <= run_lim) begin
        if (rel == 1) exp_ovf = 0;
        if (!m_legal) begin
          e_busy = (rel == 1);
          e_done = (rel == 2);
          e_err  = (rel == 2);
        end else begin
          per = m_kl + 2;
          tot = M * N * per;
          e_busy = (rel <= tot);
          if (rel <= tot && rel % per == 0) begin
            e_we = 1;
            idx = rel / per - 1;
          end
          e_done = (rel == tot + 1);
        end
      end
      chk("c_we", 32'(c_we), 32'(e_we));
      chk("busy", 32'(busy), 32'(e_busy));
      chk("done", 32'(done), 32'(e_done));
      chk("err", 32'(err), 32'(e_err));
      chk("ovf", 32'(ovf), 32'(exp_ovf));
      if (c_we === 1'b1) wr_cnt++;
      if (done === 1'b1) done_cnt++;
      if (e_we) begin
        chk("c_addr", 32'(c_addr), 32'(idx));
        chk("c_data", 32'(c_data), 32'(exp_c[idx]));
        if (exp_v[idx]) exp_ovf = 1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_const(input logic [7:0] av, input logic [7:0] bv);
    foreach (a_mem[x]) a_mem[x] = av;
    foreach (b_mem[x]) b_mem[x] = bv;
  endtask

  task automatic fill_rand();
    foreach (a_mem[x]) a_mem[x] = 8'($urandom);
    foreach (b_mem[x]) b_mem[x] = 8'($urandom);
  endtask

  task automatic go(input int kl, input bit sg, input bit sat);
    m_kl = kl;
    m_legal = (kl >= 1) && (kl <= K);
    if (m_legal) model(kl, sg, sat);
    k_len = 6'(kl);
    signed_en = sg;
    sat_en = sat;
    start = 1'b1;
    st_cyc = cyc;
    run_lim = 1 << 30;
    run_act = 1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_run(input bit scr, input bit spam);
    int tot, d0, w0;
    tot = m_legal ? M*N*(m_kl+2) + 1 : 2;
    d0 = done_cnt;
    w0 = wr_cnt;
    while (cyc - st_cyc <= tot + 1) begin
      if (scr) begin
        k_len = 6'($urandom);
        signed_en = 1'($urandom);
        sat_en = 1'($urandom);
      end
      start = spam && (cyc - st_cyc < tot - 1);
      tick();
    end
    start = 1'b0;
    chk("done_count", 32'(done_cnt - d0), 1);
    chk("write_count", 32'(wr_cnt - w0), m_legal ? M*N : 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int d0, w0;
    fill_rand();
    #2;
    mon_en = 1;
    chk("rst_a_addr", 32'(a_addr), 0);
    chk("rst_b_addr", 32'(b_addr), 0);
    chk("rst_c_addr", 32'(c_addr), 0);
    chk("rst_c_data", 32'(c_data), 0);
    tick();
    tick();
    rst = 1'b0;
    tick();

    fill_const(8'd1, 8'd2);
    go(4, 0, 0);
    chk("pin_ones", 32'(exp_c[0]), 8);
    wait_run(0, 0);
    chk("ovf_ones", 32'(ovf), 0);

    fill_const(8'd255, 8'd255);
    go(32, 0, 1);
    chk("pin_sat", 32'(exp_c[5]), 32'hFFFF);
    wait_run(0, 0);
    chk("ovf_sat", 32'(ovf), 1);

    go(32, 0, 0);
    chk("pin_wrap", 32'(exp_c[15]), 32'hC020);
    wait_run(1, 0);
    chk("ovf_wrap", 32'(ovf), 1);

    fill_rand();
    a_mem[0] = 8'hFE; a_mem[1] = 8'h03; a_mem[2] = 8'hFF;
    b_mem[0] = 8'h04; b_mem[N] = 8'hFB; b_mem[2*N] = 8'h07;
    go(3, 1, 0);
    chk("pin_signed", 32'(exp_c[0]), 32'hFFE2);
    wait_run(1, 0);
    go(3, 0, 0);
    chk("pin_unsigned", 32'(exp_c[0]), 3554);
    wait_run(0, 0);

    go(0, 0, 0);
    wait_run(0, 0);
    go(33, 0, 0);
    wait_run(0, 0);

    fill_const(8'd255, 8'd255);
    d0 = done_cnt;
    w0 = wr_cnt;
    go(4, 0, 1);
    while (cyc - st_cyc < 19) tick();
    run_lim = 19;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    repeat (12) tick();
    chk("abort_writes", 32'(wr_cnt - w0), 3);
    chk("abort_done", 32'(done_cnt - d0), 0);
    chk("abort_ovf", 32'(ovf), 1);

    fill_rand();
    d0 = done_cnt;
    w0 = wr_cnt;
    go(8, 1, 0);
    while (cyc - st_cyc < 20) tick();
    run_lim = 19;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    repeat (5) tick();
    chk("rst_writes", 32'(wr_cnt - w0), 1);
    chk("rst_done", 32'(done_cnt - d0), 0);

    fill_const(8'd1, 8'd2);
    go(4, 0, 0);
    wait_run(0, 0);
    chk("ovf_clean", 32'(ovf), 0);

    fill_rand();
    go(5, 1, 1);
    wait_run(1, 1);

    repeat (6) begin
      fill_rand();
      go($urandom_range(1, K), 1'($urandom), 1'($urandom));
      wait_run(1, 0);
    end

    repeat (3) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
